// File: rtl/wave_dac_spi_if.sv
// Signal bundle between the waveform sample sources and the serial DAC driver.
// The master side feeds samples and controls; the slave side drives the SPI pins and status.
interface wave_dac_spi_if;
    logic [7:0] i_sine;
    logic [7:0] i_squ;
    logic [7:0] i_tri;
    logic [1:0] i_sel;
    logic [4:0] i_gain;
    logic       i_en;
    logic       o_sclk;
    logic       o_mosi;
    logic       o_cs_n;
    logic       o_busy;
    logic [7:0] o_sample;
    logic       o_ovf;

    modport master (
        output i_sine, i_squ, i_tri, i_sel, i_gain, i_en,
        input  o_sclk, o_mosi, o_cs_n, o_busy, o_sample, o_ovf
    );

    modport slave (
        input  i_sine, i_squ, i_tri, i_sel, i_gain, i_en,
        output o_sclk, o_mosi, o_cs_n, o_busy, o_sample, o_ovf
    );
endinterface

// File: rtl/wave_dac_spi.sv
// Decimates the waveform sample stream, applies gain about mid-scale and
// shifts each resulting code out to an 8-bit serial DAC (SPI mode 0, 16-bit frame).
module wave_dac_spi #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    wave_dac_spi_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_cnt_reg, div_cnt_next;
    logic [PW-1:0]   ph_cnt_reg, ph_cnt_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic            sclk_reg, sclk_next;
    logic [15:0]     shift_reg, shift_next;
    logic [7:0]      code_reg, code_next;
    logic [7:0]      sample_reg, sample_next;
    logic            ovf_reg, ovf_next;

    logic            tick;
    logic [7:0]      code_sel;
    logic [4:0]      gain_sat;
    logic signed [8:0]  s_val;
    logic signed [13:0] s_ext, g_ext, prod, prod_sh;
    logic [7:0]      scaled;

    assign tick = bus.i_en && (div_cnt_reg == DIV_LAST);

    // Gain is applied to the signed offset from mid-scale; the floor shift keeps
    // the result inside 0..255 for every legal gain, so no clamp follows.
    always_comb begin
        code_sel = 8'h80;
        case (bus.i_sel)
            2'b00:   code_sel = bus.i_sine;
            2'b01:   code_sel = bus.i_squ;
            2'b10:   code_sel = bus.i_tri;
            default: code_sel = 8'h80;
        endcase
        gain_sat = (bus.i_gain > 5'd16) ? 5'd16 : bus.i_gain;
        s_val    = $signed({1'b0, code_sel}) - 9'sd128;
        s_ext    = 14'(s_val);
        g_ext    = 14'($signed({1'b0, gain_sat}));
        prod     = s_ext * g_ext;
        prod_sh  = prod >>> 4;
        scaled   = 8'h80 + prod_sh[7:0];
    end

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        ph_cnt_next  = ph_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        sclk_next    = sclk_reg;
        shift_next   = shift_reg;
        code_next    = code_reg;
        sample_next  = sample_reg;
        ovf_next     = ovf_reg;

        if (!bus.i_en)
            div_cnt_next = '0;
        else if (div_cnt_reg == DIV_LAST)
            div_cnt_next = '0;
        else
            div_cnt_next = div_cnt_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next   = SHIFT;
                    shift_next   = {4'b0011, scaled, 4'b0000};
                    code_next    = scaled;
                    ph_cnt_next  = '0;
                    bit_cnt_next = 4'd0;
                    sclk_next    = 1'b0;
                end
            end
            SHIFT: begin
                // A tick landing on a busy frame is dropped and remembered.
                if (tick)
                    ovf_next = 1'b1;
                if (ph_cnt_reg == PH_LAST) begin
                    ph_cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == 4'd15) begin
                            state_next  = IDLE;
                            sample_next = code_reg;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                            shift_next   = {shift_reg[14:0], 1'b0};
                        end
                    end
                end else begin
                    ph_cnt_next = ph_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            ph_cnt_reg  <= '0;
            bit_cnt_reg <= 4'd0;
            sclk_reg    <= 1'b0;
            shift_reg   <= 16'h0000;
            code_reg    <= 8'h80;
            sample_reg  <= 8'h80;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            ph_cnt_reg  <= ph_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            sclk_reg    <= sclk_next;
            shift_reg   <= shift_next;
            code_reg    <= code_next;
            sample_reg  <= sample_next;
            ovf_reg     <= ovf_next;
        end
    end

    // Chip select, busy and MOSI derive from the state register so they all
    // change on the same edge and drop straight to idle values on reset.
    assign bus.o_sclk   = sclk_reg;
    assign bus.o_cs_n   = (state_reg != SHIFT);
    assign bus.o_busy   = (state_reg == SHIFT);
    assign bus.o_mosi   = (state_reg == SHIFT) & shift_reg[15];
    assign bus.o_sample = sample_reg;
    assign bus.o_ovf    = ovf_reg;
endmodule

// File: tb/tb_wave_dac_spi.sv
// Bench for wave_dac_spi: a table of sample/gain/select vectors plus hand-built
// sequences for enable drop, mid-frame reset and overrun at a short sample period.
module tb_wave_dac_spi;
    localparam int SD_A = 256;
    localparam int SD_B = 100;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          low;
        logic [7:0]  sample;
    } frame_t;

    typedef struct {
        logic [1:0] sel;
        logic [4:0] gain;
        logic [7:0] sine;
        logic [7:0] squ;
        logic [7:0] tri_v;
        logic [7:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    always #5 clk = ~clk;

    wave_dac_spi_if ifa ();
    wave_dac_spi_if ifb ();

    wave_dac_spi dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa.slave));
    wave_dac_spi #(.CLK_DIV(4), .SAMPLE_DIV(SD_B)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb.slave));

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    frame_t      got_q[$];

    // Frame decoder for DUT A: shifts MOSI on each SCLK rise while CS is low.
    logic prev_sclk_a, prev_cs_a;
    logic [15:0] sh_a;
    int nb_a, low_a;
    int falls_a = 0;
    always @(negedge clk) begin
        if (!rst_n_a) begin
            prev_sclk_a <= 1'b0;
            prev_cs_a   <= 1'b1;
            sh_a        <= 16'h0;
            nb_a        <= 0;
            low_a       <= 0;
        end else begin
            prev_sclk_a <= ifa.o_sclk;
            prev_cs_a   <= ifa.o_cs_n;
            if (!ifa.o_cs_n) begin
                low_a <= prev_cs_a ? 1 : low_a + 1;
                if (prev_cs_a) begin
                    nb_a    <= 0;
                    sh_a    <= 16'h0;
                    falls_a <= falls_a + 1;
                end else if (ifa.o_sclk && !prev_sclk_a) begin
                    sh_a <= {sh_a[14:0], ifa.o_mosi};
                    nb_a <= nb_a + 1;
                end
            end else if (!prev_cs_a) begin
                got_q.push_back('{frame: sh_a, nbits: nb_a, low: low_a, sample: ifa.o_sample});
            end
        end
    end

    // DUT B only needs frame counts and shape errors.
    logic prev_sclk_b, prev_cs_b;
    int nb_b, low_b;
    int frames_b = 0;
    int bad_b = 0;
    always @(negedge clk) begin
        if (!rst_n_b) begin
            prev_sclk_b <= 1'b0;
            prev_cs_b   <= 1'b1;
            nb_b        <= 0;
            low_b       <= 0;
        end else begin
            prev_sclk_b <= ifb.o_sclk;
            prev_cs_b   <= ifb.o_cs_n;
            if (!ifb.o_cs_n) begin
                low_b <= prev_cs_b ? 1 : low_b + 1;
                if (prev_cs_b)
                    nb_b <= 0;
                else if (ifb.o_sclk && !prev_sclk_b)
                    nb_b <= nb_b + 1;
            end else if (!prev_cs_b) begin
                frames_b <= frames_b + 1;
                if (nb_b != 16 || low_b != 128)
                    bad_b <= bad_b + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        ifa.i_sel  = v.sel;
        ifa.i_gain = v.gain;
        ifa.i_sine = v.sine;
        ifa.i_squ  = v.squ;
        ifa.i_tri  = v.tri_v;
        exp_q.push_back({4'h3, v.code, 4'h0});
    endtask

    task automatic check_next(input string tag);
        frame_t f;
        logic [15:0] e;
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_timeout: no frame within 1000 cycles, expected one", tag);
            return;
        end
        f = got_q.pop_front();
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_unexpected: got frame 0x%0h, expected none", tag, f.frame);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_frame"}, 32'(f.frame), 32'(e));
        chk({tag, "_bits"}, f.nbits, 16);
        chk({tag, "_cslow"}, f.low, 128);
        chk({tag, "_sample"}, 32'(f.sample), 32'(e[11:4]));
        $display("frame %s: 0x%04h (bits=%0d cs_low=%0d sample=0x%02h)", tag, f.frame, f.nbits, f.low, f.sample);
    endtask

    task automatic wait_cs_low(input string tag);
        int n;
        n = 0;
        while (ifa.o_cs_n !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ifa.o_cs_n !== 1'b0) begin
            n_total++;
            $display("FAIL %s_cs_timeout: cs_n=%b, expected 0 within 1000 cycles", tag, ifa.o_cs_n);
        end
    endtask

    // Called right after a negedge release of reset or enable: first tick on edge SD_A.
    task automatic check_first_tick(input string tag);
        repeat (SD_A - 1) @(posedge clk);
        #1 chk({tag, "_cs_quiet"}, 32'(ifa.o_cs_n), 32'd1);
        @(posedge clk);
        #1 chk({tag, "_cs_fall"}, 32'(ifa.o_cs_n), 32'd0);
        chk({tag, "_busy"}, 32'(ifa.o_busy), 32'd1);
        chk({tag, "_mosi15"}, 32'(ifa.o_mosi), 32'd0);
        chk({tag, "_sclk"}, 32'(ifa.o_sclk), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sclk"}, 32'(ifa.o_sclk), 32'd0);
        chk({tag, "_mosi"}, 32'(ifa.o_mosi), 32'd0);
        chk({tag, "_cs_n"}, 32'(ifa.o_cs_n), 32'd1);
        chk({tag, "_busy"}, 32'(ifa.o_busy), 32'd0);
        chk({tag, "_sample"}, 32'(ifa.o_sample), 32'h80);
        chk({tag, "_ovf"}, 32'(ifa.o_ovf), 32'd0);
    endtask

    vec_t vecs[12];
    vec_t v;
    int f_before;

    initial begin
        vecs[0]  = '{2'b00, 5'd16, 8'hC0, 8'h11, 8'h22, 8'hC0};
        vecs[1]  = '{2'b00, 5'd8,  8'hC0, 8'h11, 8'h22, 8'hA0};
        vecs[2]  = '{2'b01, 5'd8,  8'hF0, 8'h00, 8'h22, 8'h40};
        vecs[3]  = '{2'b10, 5'd8,  8'h00, 8'h33, 8'hFF, 8'hBF};
        vecs[4]  = '{2'b00, 5'd0,  8'hFF, 8'h00, 8'h00, 8'h80};
        vecs[5]  = '{2'b01, 5'd31, 8'hAA, 8'h37, 8'h55, 8'h37};
        vecs[6]  = '{2'b11, 5'd16, 8'h12, 8'hEE, 8'h01, 8'h80};
        vecs[7]  = '{2'b10, 5'd17, 8'h99, 8'h88, 8'h10, 8'h10};
        vecs[8]  = '{2'b00, 5'd4,  8'h00, 8'hFF, 8'hFF, 8'h60};
        vecs[9]  = '{2'b01, 5'd3,  8'h00, 8'h81, 8'h00, 8'h80};
        vecs[10] = '{2'b10, 5'd3,  8'hFF, 8'hFF, 8'h7F, 8'h7F};
        vecs[11] = '{2'b00, 5'd15, 8'hFF, 8'h00, 8'h00, 8'hF7};

        ifa.i_en = 1'b0; ifa.i_sel = 2'b00; ifa.i_gain = 5'd16;
        ifa.i_sine = 8'h80; ifa.i_squ = 8'h80; ifa.i_tri = 8'h80;
        ifb.i_en = 1'b0; ifb.i_sel = 2'b00; ifb.i_gain = 5'd16;
        ifb.i_sine = 8'h55; ifb.i_squ = 8'h00; ifb.i_tri = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_vals("por");

        // First frame after reset: latency, shape and content.
        drive(vecs[0]);
        ifa.i_en = 1'b1;
        rst_n_a = 1'b1;
        check_first_tick("first");
        check_next("first");
        chk("ovf_idle", 32'(ifa.o_ovf), 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            check_next($sformatf("vec%0d", i));
        end

        // Select and gain change mid-frame must not disturb the captured code.
        v = '{2'b00, 5'd16, 8'h90, 8'h00, 8'h00, 8'h90};
        drive(v);
        wait_cs_low("midchg");
        repeat (40) @(negedge clk);
        v = '{2'b01, 5'd0, 8'h10, 8'h00, 8'h00, 8'h80};
        drive(v);
        check_next("midchg_cur");
        check_next("midchg_next");

        // Enable dropped halfway: frame completes, then silence until re-enabled.
        v = '{2'b00, 5'd16, 8'hD0, 8'h00, 8'h00, 8'hD0};
        drive(v);
        wait_cs_low("endrop");
        repeat (64) @(negedge clk);
        ifa.i_en = 1'b0;
        check_next("endrop");
        f_before = falls_a;
        repeat (400) @(negedge clk);
        chk("endrop_no_cs", falls_a, f_before);
        chk("endrop_no_frame", got_q.size(), 0);
        exp_q.push_back({4'h3, 8'hD0, 4'h0});
        ifa.i_en = 1'b1;
        check_first_tick("reen");
        check_next("reen");

        // Asynchronous reset in the middle of a frame.
        v = '{2'b00, 5'd16, 8'h33, 8'h00, 8'h00, 8'h33};
        drive(v);
        wait_cs_low("rstmid");
        repeat (20) @(posedge clk);
        #1 rst_n_a = 1'b0;
        #1 check_reset_vals("rstmid");
        exp_q.delete();
        repeat (3) @(negedge clk);
        v = '{2'b00, 5'd16, 8'h44, 8'h00, 8'h00, 8'h44};
        drive(v);
        rst_n_a = 1'b1;
        check_first_tick("postrst");
        check_next("postrst");

        // Short sample period: second tick lands on a busy frame.
        @(negedge clk);
        ifb.i_en = 1'b1;
        rst_n_b = 1'b1;
        repeat (SD_B * 2 - 1) @(posedge clk);
        #1 chk("ovf_before", 32'(ifb.o_ovf), 32'd0);
        @(posedge clk);
        #1 chk("ovf_set", 32'(ifb.o_ovf), 32'd1);
        chk("ovf_busy", 32'(ifb.o_busy), 32'd1);
        repeat (450) @(posedge clk);
        #1 chk("ovf_frames", frames_b, 3);
        chk("ovf_bad_frames", bad_b, 0);
        chk("ovf_sample", 32'(ifb.o_sample), 32'h55);
        chk("ovf_sticky", 32'(ifb.o_ovf), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
